// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared constants for the 7-segment scan driver
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    // All segments dark, active-low
    localparam logic [6:0] SEG7_OFF = 7'h7F;

    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Width of a digit index register for an n-digit display
    function automatic int seg7_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// seg7_hex_decode : hex nibble to active-low gfedcba segment pattern
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = ~SEG7_HEX[nibble_i];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver : time-multiplexed N-digit 7-segment driver with blanking,
//                    leading-zero suppression and optional blink (SEG7_BLINK_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_LOG2 = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   points,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lz_en,
`ifdef SEG7_BLINK_EN
    input  logic [N_DIGITS-1:0]   blink,
`endif
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = seg7_idx_w(N_DIGITS);

    logic [PW-1:0]         presc_q;
    logic [IW-1:0]         idx_q;
    logic [4*N_DIGITS-1:0] digits_q;
    logic [N_DIGITS-1:0]   points_q;
    logic [N_DIGITS-1:0]   blank_q;

    logic                  tc;
    logic [3:0]            sel_nib;
    logic [6:0]            dec_seg_n;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  upper_zero;
    logic                  force_dark;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [N_DIGITS-1:0]   an_d;

    assign tc      = (presc_q == PW'(SCAN_DIV - 1));
    assign sel_nib = digits_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble_i (sel_nib),
        .seg_n_o  (dec_seg_n)
    );

`ifdef SEG7_BLINK_EN
    logic [N_DIGITS-1:0]   blink_q;
    logic [BLINK_LOG2-1:0] blink_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q     <= '0;
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
            if (load) begin
                blink_q <= blink;
            end
        end
    end

    assign force_dark = blank_q[idx_q] | (blink_q[idx_q] & blink_cnt_q[BLINK_LOG2-1]);
`else
    assign force_dark = blank_q[idx_q];
`endif

    // Digit k is a leading zero when it and every more significant nibble are zero
    always_comb begin
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (digits_q[4*k +: 4] == 4'h0);
            lz_mask[k] = upper_zero;
        end
    end

    always_comb begin
        an_d  = ~(N_DIGITS'(1) << idx_q);
        seg_d = dec_seg_n;
        dp_d  = ~points_q[idx_q];
        if (force_dark) begin
            seg_d = SEG7_OFF;
            dp_d  = 1'b1;
        end else if (lz_en && lz_mask[idx_q]) begin
            seg_d = SEG7_OFF;
        end
        // One dark cycle on every slot change keeps the old digit from ghosting
        if (tc) begin
            an_d  = '1;
            seg_d = SEG7_OFF;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            digits_q <= '0;
            points_q <= '0;
            blank_q  <= '1;
            seg_n    <= SEG7_OFF;
            dp_n     <= 1'b1;
            an_n     <= '1;
        end else begin
            if (tc) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            if (load) begin
                digits_q <= digits;
                points_q <= points;
                blank_q  <= blank;
            end
            seg_n <= seg_d;
            dp_n  <= dp_d;
            an_n  <= an_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver : scoreboard bench, N_DIGITS=4, SCAN_DIV=4
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

    localparam int N_DIGITS = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  points = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic        lz_en = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS   (N_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_LOG2 (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .digits (digits),
        .points (points),
        .blank  (blank),
        .lz_en  (lz_en),
`ifdef SEG7_BLINK_EN
        .blink  (blink),
`endif
        .seg_n  (seg_n),
        .dp_n   (dp_n),
        .an_n   (an_n)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } rec_t;

    rec_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   edges    = 0;

    // Edges since reset release: the bench's own timebase for slot order
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a new lit slot (dead cycle followed by a selected digit) pops one record
    rec_t cur;
    bit   active    = 1'b0;
    bit   prev_dead = 1'b1;
    int   lit       = 0;

    always @(negedge clk) begin
        if (rst) begin
            active    = 1'b0;
            prev_dead = 1'b1;
        end else begin
            if (an_n != 4'hF && prev_dead && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("slot_an", {28'd0, an_n}, {28'd0, cur.an});
                check("slot_seg", {25'd0, seg_n}, {25'd0, cur.seg});
                check("slot_dp", {31'd0, dp_n}, {31'd0, cur.dp});
                active = 1'b1;
                lit    = 1;
            end else if (active && an_n != 4'hF) begin
                if ({an_n, seg_n, dp_n} == cur) lit++;
            end
            if (active && an_n == 4'hF) begin
                check("slot_len", lit, SCAN_DIV - 1);
                active = 1'b0;
            end
            prev_dead = (an_n == 4'hF);
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || active) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || active) begin
            n_assert++;
            n_fail++;
            $display("FAIL idle_timeout: actual %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic wait_phase(input int ph);
        int t = 0;
        while ((edges % SCAN_DIV) != ph && t < 16) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic push_frame(input int first, input logic [27:0] es, input logic [3:0] edp);
        rec_t r;
        for (int i = 0; i < N_DIGITS; i++) begin
            int k;
            k     = (first + i) % N_DIGITS;
            r.an  = ~(4'b0001 << k);
            r.seg = es[k*7 +: 7];
            r.dp  = edp[k];
            exp_q.push_back(r);
        end
    endtask

    // es = {seg3, seg2, seg1, seg0} active-low; edp = {dp3..dp0} active-low
    task automatic run_case(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                            input logic lz, input logic [27:0] es, input logic [3:0] edp);
        wait_idle();
        @(negedge clk);
        digits = d; points = p; blank = b; lz_en = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_phase(0);
        push_frame(edges / SCAN_DIV, es, edp);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg_n}, 32'h7F);
        check("rst_dp", {31'd0, dp_n}, 32'd1);
        check("rst_an", {28'd0, an_n}, 32'hF);
        rst = 1'b0;

        // No load yet: scanning runs but every slot stays dark
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("dark_seg", {25'd0, seg_n}, 32'h7F);
            check("dark_dp", {31'd0, dp_n}, 32'd1);
            check("dark_an_onehot", {31'd0, ($countones(~an_n) <= 1)}, 32'd1);
        end

        // 12AF: F->71, A->77, 2->5B, 1->06
        run_case(16'h12AF, 4'b0000, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);
        // 0045 with LZ: digits 3,2 dark, digit 3 point lit; 4->66, 5->6D
        run_case(16'h0045, 4'b1000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h12}, 4'b0111);
        // All zero with LZ: only digit 0 shows 0 (3F)
        run_case(16'h0000, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
        // 8888 with digit 1 blanked: blank overrides its point
        run_case(16'h8888, 4'b0011, 4'b0010, 1'b0, {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1110);

        // Load on the terminal-count edge: the very next slot shows 5 (6D)
        wait_idle();
        wait_phase(SCAN_DIV - 1);
        digits = 16'h5555; points = 4'b0000; blank = 4'b0000; lz_en = 1'b0; load = 1'b1;
        push_frame((edges + 1) / SCAN_DIV, {4{7'h12}}, 4'b1111);
        @(negedge clk);
        load = 1'b0;
        wait_idle();

        // Reset mid-slot, with a load held during reset that must be ignored
        wait_phase(1);
        rst = 1'b1; load = 1'b1; digits = 16'h1111; points = 4'hF;
        @(negedge clk);
        check("midrst_seg", {25'd0, seg_n}, 32'h7F);
        check("midrst_dp", {31'd0, dp_n}, 32'd1);
        check("midrst_an", {28'd0, an_n}, 32'hF);
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("postrst_seg", {25'd0, seg_n}, 32'h7F);
            check("postrst_dp", {31'd0, dp_n}, 32'd1);
        end

`ifdef SEG7_BLINK_EN
        // Digit 0 blinks with the counter MSB; counter value is edges-1 at the output
        @(negedge clk);
        digits = 16'h1111; points = 4'b0000; blank = 4'b0000; blink = 4'b0001; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (an_n != 4'hF) begin
                if (an_n == 4'b1110 && (((edges - 1) % 16) >= 8))
                    check("blink_dark", {25'd0, seg_n}, 32'h7F);
                else
                    check("blink_lit", {25'd0, seg_n}, 32'h79);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
